// File: rtl/video_cfg_sequencer.sv
// Configuration sequencer: a debounced key press or a bypass-switch change launches
// one Avalon-MM write to the bar core, then one to the rgb2gray core, each with a stall timeout.
module video_cfg_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WAIT_TIMEOUT    = 255,
    parameter bit          AUTO_UPDATE     = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_n,
    input  logic [1:0]  bypass_sw,
    output logic        avs_bar_address,
    output logic        avs_bar_write,
    output logic [31:0] avs_bar_writedata,
    input  logic        avs_bar_waitrequest,
    output logic        avs_gray_address,
    output logic        avs_gray_write,
    output logic [31:0] avs_gray_writedata,
    input  logic        avs_gray_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [7:0]  seq_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TO_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_BAR  = 2'd1,
        S_WR_GRAY = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    logic            r_key_s1, r_key_s2;
    logic [1:0]      r_sw_s1, r_sw_s2;
    logic            r_db_level, r_db_d, r_trig;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_chg;
    logic            r_pending;
    logic [1:0]      r_snap;
    logic [1:0]      w_snap_next;
    logic [TO_W-1:0] r_stall_cnt;
    state_t          r_state, w_next;
    logic            w_launch, w_timeout, w_stall_inc;
    logic            r_bar_write, r_gray_write;
    logic [31:0]     r_bar_wdata, r_gray_wdata;
    logic            r_busy, r_done, r_timeout_err;
    logic [7:0]      r_seq_count;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_sw_s1  <= 2'b00;
            r_sw_s2  <= 2'b00;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= bypass_sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Key debouncer; trigger fires one cycle after the debounced level falls
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_db_level <= 1'b1;
            r_db_d     <= 1'b1;
            r_trig     <= 1'b0;
            r_db_cnt   <= {DB_W{1'b0}};
        end else begin
            r_db_d <= r_db_level;
            r_trig <= r_db_d & ~r_db_level;
            if (r_key_s2 == r_db_level) begin
                r_db_cnt <= {DB_W{1'b0}};
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_key_s2;
                r_db_cnt   <= {DB_W{1'b0}};
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    generate
        if (AUTO_UPDATE) begin : g_auto
            logic [1:0] r_sw_copy;
            logic       r_chg;
            // Switch change detector against a registered copy
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_sw_copy <= 2'b00;
                    r_chg     <= 1'b0;
                end else begin
                    r_sw_copy <= r_sw_s2;
                    r_chg     <= |(r_sw_s2 ^ r_sw_copy);
                end
            end
            assign w_chg = r_chg;
        end else begin : g_manual
            assign w_chg = 1'b0;
        end
    endgenerate

    assign w_snap_next = w_launch ? r_sw_s2 : r_snap;

    // Request latch (a new request beats the launch clear) and bypass snapshot
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pending <= 1'b0;
            r_snap    <= 2'b00;
        end else begin
            r_pending <= r_trig | w_chg | (r_pending & ~w_launch);
            r_snap    <= w_snap_next;
        end
    end

    // Sequencer state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; waitrequest low takes priority over the timeout
    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_timeout   = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_next   = S_WR_BAR;
                    w_launch = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WR_BAR: begin
                if (!avs_bar_waitrequest) begin
                    w_next = S_WR_GRAY;
                end else if (r_stall_cnt == TO_LAST) begin
                    w_next    = S_WR_GRAY;
                    w_timeout = 1'b1;
                end else begin
                    w_stall_inc = 1'b1;
                end
            end
            S_WR_GRAY: begin
                if (!avs_gray_waitrequest) begin
                    w_next = S_DONE;
                end else if (r_stall_cnt == TO_LAST) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_stall_inc = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Stall counter, restarted on every state change
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stall_cnt <= {TO_W{1'b0}};
        end else if (w_next != r_state) begin
            r_stall_cnt <= {TO_W{1'b0}};
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + TO_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Outputs registered from the next state so they line up with the state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bar_write   <= 1'b0;
            r_gray_write  <= 1'b0;
            r_bar_wdata   <= 32'd0;
            r_gray_wdata  <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_seq_count   <= 8'd0;
        end else begin
            r_bar_write   <= (w_next == S_WR_BAR);
            r_gray_write  <= (w_next == S_WR_GRAY);
            r_bar_wdata   <= (w_next == S_WR_BAR)  ? {31'd0, w_snap_next[0]} : 32'd0;
            r_gray_wdata  <= (w_next == S_WR_GRAY) ? {31'd0, w_snap_next[1]} : 32'd0;
            r_busy        <= (w_next != S_IDLE);
            r_done        <= (w_next == S_DONE);
            r_timeout_err <= r_timeout_err | w_timeout;
            if (w_next == S_DONE) begin
                r_seq_count <= r_seq_count + 8'd1;
            end else begin
                r_seq_count <= r_seq_count;
            end
        end
    end

    assign avs_bar_address    = 1'b0;
    assign avs_gray_address   = 1'b0;
    assign avs_bar_write      = r_bar_write;
    assign avs_gray_write     = r_gray_write;
    assign avs_bar_writedata  = r_bar_wdata;
    assign avs_gray_writedata = r_gray_wdata;
    assign busy               = r_busy;
    assign done               = r_done;
    assign timeout_err        = r_timeout_err;
    assign seq_count          = r_seq_count;

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Self-checking bench for video_cfg_sequencer: table vectors, hand-written corner
// sequences and a randomized phase judged by a transaction-level model.
module tb_video_cfg_sequencer;

    localparam int DB = 4;
    localparam int WT = 6;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_n = 1'b1;
    logic [1:0]  bypass_sw = 2'b00;
    logic        avs_bar_address, avs_bar_write, avs_bar_waitrequest;
    logic [31:0] avs_bar_writedata;
    logic        avs_gray_address, avs_gray_write, avs_gray_waitrequest;
    logic [31:0] avs_gray_writedata;
    logic        busy, done, timeout_err;
    logic [7:0]  seq_count;

    video_cfg_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .WAIT_TIMEOUT   (WT),
        .AUTO_UPDATE    (1'b1)
    ) dut (
        .sys_clk             (sys_clk),
        .sys_rst_n           (sys_rst_n),
        .key_n               (key_n),
        .bypass_sw           (bypass_sw),
        .avs_bar_address     (avs_bar_address),
        .avs_bar_write       (avs_bar_write),
        .avs_bar_writedata   (avs_bar_writedata),
        .avs_bar_waitrequest (avs_bar_waitrequest),
        .avs_gray_address    (avs_gray_address),
        .avs_gray_write      (avs_gray_write),
        .avs_gray_writedata  (avs_gray_writedata),
        .avs_gray_waitrequest(avs_gray_waitrequest),
        .busy                (busy),
        .done                (done),
        .timeout_err         (timeout_err),
        .seq_count           (seq_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0] sw;
        int bs; int gs;
        int exp_seq; int exp_bd; int exp_gd;
        int exp_bl; int exp_gl; int exp_busy; int exp_tmo;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // stall config: -1 = waitrequest stuck high
    int bar_stall_cfg = 0, gray_stall_cfg = 0;
    int rb_run = 0, rg_run = 0;

    int bar_run = 0, gray_run = 0, busy_run = 0;
    int bar_dat = 0, gray_dat = 0;
    int q_bdat[$], q_blen[$], q_gdat[$], q_glen[$], q_busy[$];
    int done_cnt = 0, viol = 0, strobe_cycles = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pop_q(input int sel);
        int v;
        v = -1;
        case (sel)
            0: if (q_bdat.size() > 0) v = q_bdat.pop_front();
            1: if (q_gdat.size() > 0) v = q_gdat.pop_front();
            2: if (q_blen.size() > 0) v = q_blen.pop_front();
            3: if (q_glen.size() > 0) v = q_glen.pop_front();
            4: if (q_busy.size() > 0) v = q_busy.pop_front();
            default: v = -1;
        endcase
        return v;
    endfunction

    task automatic clear_q();
        q_bdat.delete(); q_gdat.delete(); q_blen.delete(); q_glen.delete(); q_busy.delete();
    endtask

    task automatic check_seq(input string tag, input int bd, input int gd,
                             input int bl, input int gl, input int bz);
        check({tag, " bar_wdata"},  pop_q(0), bd);
        check({tag, " gray_wdata"}, pop_q(1), gd);
        check({tag, " bar_len"},    pop_q(2), bl);
        check({tag, " gray_len"},   pop_q(3), gl);
        check({tag, " busy_len"},   pop_q(4), bz);
    endtask

    task automatic wait_bar_write(output int lat);
        lat = 0;
        while (!avs_bar_write && lat < 60) begin
            @(negedge sys_clk);
            lat++;
        end
        if (!avs_bar_write) lat = -1;
    endtask

    task automatic wait_done(input int start, input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, " done_count"}, done_cnt - start, target - start);
        repeat (2) @(negedge sys_clk);
    endtask

    // Avalon slave responder: stall each write for the configured number of cycles
    initial begin
        avs_bar_waitrequest  = 1'b0;
        avs_gray_waitrequest = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (avs_bar_write) begin
                avs_bar_waitrequest = (bar_stall_cfg < 0) || (rb_run < bar_stall_cfg);
                rb_run++;
            end else begin
                avs_bar_waitrequest = 1'b0;
                rb_run = 0;
            end
            if (avs_gray_write) begin
                avs_gray_waitrequest = (gray_stall_cfg < 0) || (rg_run < gray_stall_cfg);
                rg_run++;
            end else begin
                avs_gray_waitrequest = 1'b0;
                rg_run = 0;
            end
        end
    end

    // Bus monitor: collects write runs, busy runs, done pulses and protocol violations
    initial begin
        forever begin
            @(negedge sys_clk);
            if (avs_bar_write && avs_gray_write) viol++;
            if (avs_bar_address || avs_gray_address) viol++;
            if (!avs_bar_write && avs_bar_writedata != 32'd0) viol++;
            if (!avs_gray_write && avs_gray_writedata != 32'd0) viol++;
            if (avs_bar_writedata[31:1] != 31'd0 || avs_gray_writedata[31:1] != 31'd0) viol++;
            if (avs_bar_write) begin
                bar_run++; bar_dat = int'(avs_bar_writedata); strobe_cycles++;
            end else if (bar_run > 0) begin
                q_blen.push_back(bar_run); q_bdat.push_back(bar_dat); bar_run = 0;
            end
            if (avs_gray_write) begin
                gray_run++; gray_dat = int'(avs_gray_writedata); strobe_cycles++;
            end else if (gray_run > 0) begin
                q_glen.push_back(gray_run); q_gdat.push_back(gray_dat); gray_run = 0;
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                q_busy.push_back(busy_run); busy_run = 0;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[6];
    int lat, d0, exp_cnt, exp_tmo, bl, gl;
    logic [1:0] cur_sw, nsw;
    int rbs, rgs;

    initial begin
        // sw, bar stall, gray stall, seq?, bar data, gray data, bar len, gray len, busy len, timeout
        vt[0] = '{sw:2'b10, bs:0,  gs:0,  exp_seq:1, exp_bd:0, exp_gd:1, exp_bl:1, exp_gl:1, exp_busy:3,  exp_tmo:0};
        vt[1] = '{sw:2'b10, bs:0,  gs:0,  exp_seq:0, exp_bd:0, exp_gd:0, exp_bl:0, exp_gl:0, exp_busy:0,  exp_tmo:0};
        vt[2] = '{sw:2'b01, bs:5,  gs:0,  exp_seq:1, exp_bd:1, exp_gd:0, exp_bl:6, exp_gl:1, exp_busy:8,  exp_tmo:0};
        vt[3] = '{sw:2'b11, bs:2,  gs:3,  exp_seq:1, exp_bd:1, exp_gd:1, exp_bl:3, exp_gl:4, exp_busy:8,  exp_tmo:0};
        vt[4] = '{sw:2'b00, bs:0,  gs:-1, exp_seq:1, exp_bd:0, exp_gd:0, exp_bl:1, exp_gl:WT+1, exp_busy:WT+3, exp_tmo:1};
        vt[5] = '{sw:2'b01, bs:WT, gs:0,  exp_seq:1, exp_bd:1, exp_gd:0, exp_bl:WT+1, exp_gl:1, exp_busy:WT+3, exp_tmo:1};

        // reset state
        repeat (3) @(negedge sys_clk);
        check("reset bar_write", int'(avs_bar_write), 0);
        check("reset gray_write", int'(avs_gray_write), 0);
        check("reset busy_done_tmo", int'({busy, done, timeout_err}), 0);
        check("reset seq_count", int'(seq_count), 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // key held low 10 cycles: one sequence, latency 2 sync + DB + 1 edge + 1 pending + 1 launch
        d0 = done_cnt;
        clear_q();
        key_n = 1'b0;
        wait_bar_write(lat);
        check("key latency", lat, 2 + DB + 3);
        repeat (10 - lat) @(negedge sys_clk);
        key_n = 1'b1;
        wait_done(d0, d0 + 1, "key");
        check_seq("key", 0, 0, 1, 1, 3);
        repeat (20) @(negedge sys_clk);
        check("key single seq", done_cnt - d0, 1);
        check("key seq_count", int'(seq_count), 1);

        // glitches shorter than the debounce window
        d0 = strobe_cycles;
        for (int len = 1; len <= DB - 1; len++) begin
            @(negedge sys_clk);
            key_n = 1'b0;
            repeat (len) @(negedge sys_clk);
            key_n = 1'b1;
            repeat (3) @(negedge sys_clk);
        end
        repeat (15) @(negedge sys_clk);
        check("glitch strobes", strobe_cycles - d0, 0);
        check("glitch seq_count", int'(seq_count), 1);

        // table vectors
        exp_cnt = 1;
        cur_sw  = 2'b00;
        for (int i = 0; i < 6; i++) begin
            bar_stall_cfg  = vt[i].bs;
            gray_stall_cfg = vt[i].gs;
            clear_q();
            d0 = done_cnt;
            @(negedge sys_clk);
            bypass_sw = vt[i].sw;
            cur_sw = vt[i].sw;
            if (vt[i].exp_seq != 0) begin
                wait_bar_write(lat);
                check($sformatf("vec%0d latency", i), lat, 5);
                wait_done(d0, d0 + 1, $sformatf("vec%0d", i));
                check_seq($sformatf("vec%0d", i), vt[i].exp_bd, vt[i].exp_gd,
                          vt[i].exp_bl, vt[i].exp_gl, vt[i].exp_busy);
                exp_cnt = (exp_cnt + 1) % 256;
            end else begin
                repeat (15) @(negedge sys_clk);
                check($sformatf("vec%0d no seq", i), done_cnt - d0, 0);
            end
            check($sformatf("vec%0d seq_count", i), int'(seq_count), exp_cnt);
            check($sformatf("vec%0d timeout_err", i), int'(timeout_err), vt[i].exp_tmo);
        end
        exp_tmo = 1;

        // several requests during one busy sequence collapse into a single follow-up
        bar_stall_cfg  = 5;
        gray_stall_cfg = 5;
        clear_q();
        d0 = done_cnt;
        @(negedge sys_clk);
        bypass_sw = 2'b10;
        wait_bar_write(lat);
        @(negedge sys_clk); bypass_sw = 2'b11;
        repeat (2) @(negedge sys_clk); bypass_sw = 2'b00;
        repeat (2) @(negedge sys_clk); bypass_sw = 2'b01;
        cur_sw = 2'b01;
        wait_done(d0, d0 + 2, "collapse");
        repeat (20) @(negedge sys_clk);
        check("collapse seq total", done_cnt - d0, 2);
        check_seq("collapse first", 0, 1, 6, 6, 13);
        check_seq("collapse follow", 1, 0, 6, 6, 13);
        exp_cnt = (exp_cnt + 2) % 256;
        check("collapse seq_count", int'(seq_count), exp_cnt);

        // randomized switch changes and stalls against the transaction model
        for (int i = 0; i < 16; i++) begin
            nsw = 2'($urandom_range(0, 3));
            rbs = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            rgs = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            bar_stall_cfg  = rbs;
            gray_stall_cfg = rgs;
            clear_q();
            d0 = done_cnt;
            @(negedge sys_clk);
            bypass_sw = nsw;
            if (nsw != cur_sw) begin
                bl = (rbs < 0) ? WT + 1 : rbs + 1;
                gl = (rgs < 0) ? WT + 1 : rgs + 1;
                wait_done(d0, d0 + 1, $sformatf("rnd%0d", i));
                check_seq($sformatf("rnd%0d", i), int'(nsw[0]), int'(nsw[1]), bl, gl, bl + gl + 1);
                exp_cnt = (exp_cnt + 1) % 256;
                if (rbs < 0 || rgs < 0) exp_tmo = 1;
            end else begin
                repeat (15) @(negedge sys_clk);
                check($sformatf("rnd%0d no seq", i), done_cnt - d0, 0);
            end
            cur_sw = nsw;
            check($sformatf("rnd%0d seq_count", i), int'(seq_count), exp_cnt);
            check($sformatf("rnd%0d timeout_err", i), int'(timeout_err), exp_tmo);
        end

        // asynchronous reset in the middle of the gray write
        bar_stall_cfg  = 0;
        gray_stall_cfg = -1;
        d0 = 0;
        @(negedge sys_clk);
        bypass_sw = ~cur_sw;
        while (!avs_gray_write && d0 < 60) begin
            @(negedge sys_clk);
            d0++;
        end
        check("mid-reset gray write reached", int'(avs_gray_write), 1);
        repeat (2) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        bypass_sw = 2'b00;
        gray_stall_cfg = 0;
        #1;
        check("mid-reset gray_write", int'(avs_gray_write), 0);
        check("mid-reset bar_write", int'(avs_bar_write), 0);
        check("mid-reset wdata", int'(avs_gray_writedata | avs_bar_writedata), 0);
        check("mid-reset busy_done_tmo", int'({busy, done, timeout_err}), 0);
        check("mid-reset seq_count", int'(seq_count), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        d0 = done_cnt;
        repeat (20) @(negedge sys_clk);
        check("after reset no seq", done_cnt - d0, 0);
        check("after reset busy", int'(busy), 0);

        check("protocol invariants", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/video_cfg_sequencer.md
# video_cfg_sequencer

Configuration sequencer for the video daisy-chain system. It debounces a user trigger key and watches the core-bypass switches. When a trigger or switch change occurs, it issues one Avalon-MM register write to the bar core and then one to the rgb2gray core, honouring waitrequest with a timeout. It sits in the sys_clk domain between the board I/O and the Avalon slave ports of the video cores.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles the synchronized key must hold a new level before the debounced level changes; minimum 2.
- WAIT_TIMEOUT, 255: maximum cycles a write may stall on waitrequest before it is abandoned; minimum 1.
- AUTO_UPDATE, 1: 1 = a change in the synchronized bypass bits also requests a sequence.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw trigger push button, active-low, asynchronous.
- bypass_sw  in  2  raw switches, asynchronous: bit0 = bar core bypass, bit1 = rgb2gray bypass.
- avs_bar_address  out  1  bar core register address.
- avs_bar_write  out  1  bar core write strobe.
- avs_bar_writedata  out  32  bar core write data.
- avs_bar_waitrequest  in  1  bar core stall.
- avs_gray_address  out  1  rgb2gray register address.
- avs_gray_write  out  1  rgb2gray write strobe.
- avs_gray_writedata  out  32  rgb2gray write data.
- avs_gray_waitrequest  in  1  rgb2gray stall.
- busy  out  1  high while the sequence is in WR_BAR, WR_GRAY or DONE.
- done  out  1  one-cycle pulse when a sequence ends.
- timeout_err  out  1  sticky flag, set by any abandoned write.
- seq_count  out  8  number of completed sequences; wraps 255 -> 0.

## Operation
- key_n and bypass_sw each pass through a 2-flop synchronizer; all sync flops reset to 1 for the key and 0 for the switches.
- Debouncer:
  - Debounced key level resets to 1.
  - While the synchronized key differs from the debounced level, a counter increments; any cycle with equal levels clears it.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level takes the new value and the counter clears.
  - A 1->0 transition of the debounced level generates a trigger pulse.
- Change detect (AUTO_UPDATE=1): the synchronized bypass bits are compared against a registered copy; any difference pulses a change request. The copy resets to 0.
- Request latch `pending` is set by a trigger or change pulse and cleared on the cycle IDLE launches a sequence. Any number of requests while busy collapse into one follow-up sequence. If a set and a clear coincide, set wins.
- FSM states are IDLE, WR_BAR, WR_GRAY, DONE; reset state is IDLE.
  - IDLE: if pending, snapshot the synchronized bypass bits into `snap`, clear pending, and go to WR_BAR.
  - WR_BAR: avs_bar_write=1, address=0, writedata={31'b0, snap[0]}. Go to WR_GRAY on the first cycle with waitrequest=0 (write accepted), or after the stall counter reaches WAIT_TIMEOUT (set timeout_err).
  - WR_GRAY: same rules on the gray port with snap[1].
  - DONE: pulse done, increment seq_count, then return to IDLE.
- The stall counter clears on every state entry.
- Only one write strobe is ever asserted at a time. Address and writedata are 0 whenever the corresponding write is 0.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE.
- An asynchronous reset mid-sequence drops any write immediately; pending is lost.
- Key press to trigger pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles + 1 edge-detect cycle.
- Trigger pulse to pending set: 1 cycle. Pending to avs_bar_write=1: 1 cycle.
- With zero waitrequest, a sequence takes 3 cycles: WR_BAR, WR_GRAY, DONE. busy is high for exactly those 3 cycles.
- A write stalled the whole time holds its strobe for WAIT_TIMEOUT+1 cycles.
- Switch change to change pulse: 3 cycles.
- Back-to-back sequences: IDLE occupies at least 1 cycle between DONE and the next WR_BAR.

## Test plan
- Reset with DEBOUNCE_CYCLES=4: hold key_n=0 for 10 cycles, then release. Required: exactly one sequence; bar writedata=snap[0], gray writedata=snap[1]; done pulses once; seq_count=1.
- Glitchy key (DEBOUNCE_CYCLES=4): pulses of 1-3 cycles low. Required: no write strobes; seq_count stays 0.
- AUTO_UPDATE=1, bypass_sw 00->10. Required: bar writedata=0, gray writedata=1, issued 3 cycles after sync; busy high for 3 cycles.
- Bar waitrequest held for 5 cycles with WAIT_TIMEOUT=255. Required: avs_bar_write held for 6 cycles; timeout_err=0.
- Gray waitrequest stuck high with WAIT_TIMEOUT=3. Required: gray write held for 4 cycles, then abandoned; timeout_err=1 and stays set; seq_count still increments.
- Three triggers issued during one busy sequence. Required: exactly one follow-up sequence; seq_count advances by 2 total. Additionally, assert sys_rst_n mid-WR_GRAY: all outputs return to 0 immediately.
